// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter: fetch (read-only) and data (load/store) share one port.
// Optional fetch starvation guard compiled in with MEM_ARB_STARVE_GUARD_EN.
module riscv_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   owner_d, owner_d_nx;
    logic   drop, drop_nx;
    logic   force_if;
    logic   pick_d, pick_if;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must be within 1..15");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    logic [3:0] cnt;

    assign force_if = if_req && (cnt == LIMIT);

    // Count data wins that locked out a pending fetch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (pick_d) begin
                cnt <= if_req ? cnt + 4'd1 : 4'd0;
            end else if (pick_if) begin
                cnt <= 4'd0;
            end
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign pick_d   = d_req && !force_if;
    assign pick_if  = !pick_d && if_req;
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    // State, owner and drop registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nx;
            owner_d <= owner_d_nx;
            drop    <= drop_nx;
        end
    end

    // Next-state logic and memory/requester side outputs
    always_comb begin
        state_nx   = state;
        owner_d_nx = owner_d;
        drop_nx    = drop;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'd0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        unique case (state)
            IDLE: begin
                drop_nx = 1'b0;
                if (pick_d) begin
                    owner_d_nx = 1'b1;
                    state_nx   = REQ;
                end else if (pick_if) begin
                    owner_d_nx = 1'b0;
                    state_nx   = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (owner_d) begin
                    mem_we    = d_we;
                    mem_be    = d_be;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                end else begin
                    mem_be   = 4'hF;
                    mem_addr = if_addr;
                    if (if_flush) begin
                        drop_nx = 1'b1;
                    end
                end
                if (mem_gnt) begin
                    d_gnt  = owner_d;
                    if_gnt = !owner_d;
                    if (owner_d && d_we) begin
                        state_nx = IDLE;
                        drop_nx  = 1'b0;
                    end else begin
                        state_nx = RSP;
                    end
                end
            end
            RSP: begin
                if (!owner_d && if_flush) begin
                    drop_nx = 1'b1;
                end
                if (mem_rvalid) begin
                    d_rvalid  = owner_d;
                    if_rvalid = !owner_d && !drop && !if_flush;
                    state_nx  = IDLE;
                    drop_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                drop_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed testbench for riscv_mem_arbiter.
// Expected grant order depends on MEM_ARB_STARVE_GUARD_EN.
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int fails  = 0;

    riscv_mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       gd [6];
        logic       exp_d [6];
        int         ng;
        logic       pend;

`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rstn       = 1'b0;
        if_req     = 1'b0;
        if_addr    = 32'd0;
        if_flush   = 1'b0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_be       = 4'd0;
        d_addr     = 32'd0;
        d_wdata    = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEADBEEF;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'hDEADBEEF);
        @(negedge clk);
        rstn = 1'b1;

        // lone fetch
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h100;
        mem_gnt = 1'b1;
        #1;
        chk("f_c0_mem_req", {31'd0, mem_req}, 32'd0);
        chk("f_c0_if_gnt", {31'd0, if_gnt}, 32'd0);
        @(negedge clk);
        #1;
        chk("f_c1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f_c1_mem_addr", mem_addr, 32'h100);
        chk("f_c1_mem_be", {28'd0, mem_be}, 32'hF);
        chk("f_c1_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_c1_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("f_c1_d_gnt", {31'd0, d_gnt}, 32'd0);
        @(negedge clk);
        if_req     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00500093;
        #1;
        chk("f_c2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("f_c2_if_rdata", if_rdata, 32'h00500093);
        chk("f_c2_mem_req", {31'd0, mem_req}, 32'd0);
        chk("f_c2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("f_c3_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("f_c3_mem_req", {31'd0, mem_req}, 32'd0);

        // simultaneous fetch and store: store first
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h104;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 32'h2000;
        d_wdata = 32'hBEEF;
        mem_gnt = 1'b1;
        #1;
        chk("s_c0_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("s_c1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("s_c1_mem_we", {31'd0, mem_we}, 32'd1);
        chk("s_c1_mem_be", {28'd0, mem_be}, 32'h3);
        chk("s_c1_mem_addr", mem_addr, 32'h2000);
        chk("s_c1_mem_wdata", mem_wdata, 32'hBEEF);
        chk("s_c1_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("s_c1_if_gnt", {31'd0, if_gnt}, 32'd0);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("s_c2_mem_req", {31'd0, mem_req}, 32'd0);
        chk("s_c2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        @(negedge clk);
        #1;
        chk("s_c3_mem_req", {31'd0, mem_req}, 32'd1);
        chk("s_c3_mem_addr", mem_addr, 32'h104);
        chk("s_c3_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk);
        if_req     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        #1;
        chk("s_c4_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("s_c4_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // load with memory stalling 3 cycles
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 32'h3000;
        d_wdata = 32'd0;
        mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("st%0d_mem_req", k), {31'd0, mem_req}, 32'd1);
            chk($sformatf("st%0d_mem_addr", k), mem_addr, 32'h3000);
            chk($sformatf("st%0d_mem_be", k), {28'd0, mem_be}, 32'hF);
            chk($sformatf("st%0d_d_gnt", k), {31'd0, d_gnt}, 32'd0);
        end
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk("st3_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("st3_mem_addr", mem_addr, 32'h3000);
        @(negedge clk);
        d_req      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11223344;
        #1;
        chk("st_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("st_d_rdata", d_rdata, 32'h11223344);
        chk("st_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // fetch flushed while waiting for response
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h200;
        mem_gnt = 1'b1;
        @(negedge clk);
        #1;
        chk("fl_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk);
        if_req   = 1'b0;
        mem_gnt  = 1'b0;
        if_flush = 1'b1;
        #1;
        chk("fl_rsp_wait", {31'd0, if_rvalid}, 32'd0);
        @(negedge clk);
        if_flush   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        #1;
        chk("fl_dropped", {31'd0, if_rvalid}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h300;
        mem_gnt    = 1'b1;
        #1;
        chk("fl_idle_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("fl_next_gnt", {31'd0, if_gnt}, 32'd1);
        chk("fl_next_addr", mem_addr, 32'h300);
        @(negedge clk);
        if_req     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00000013;
        #1;
        chk("fl_next_rvalid", {31'd0, if_rvalid}, 32'd1);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // both requesters held: grant order
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h400;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hF;
        d_addr  = 32'h5000;
        d_wdata = 32'h55;
        mem_gnt = 1'b1;
        ng      = 0;
        pend    = 1'b0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            mem_rvalid = pend;
            #1;
            if (d_gnt || if_gnt) begin
                gd[ng] = d_gnt;
                ng++;
            end
            pend = if_gnt;
        end
        chk("grant_count", ng, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < ng) begin
                chk($sformatf("grant%0d_is_d", k), {31'd0, gd[k]}, {31'd0, exp_d[k]});
            end
        end
        @(negedge clk);
        if_req     = 1'b0;
        d_req      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);

        // reset while a load waits for its response
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 32'h4000;
        mem_gnt = 1'b1;
        @(negedge clk);
        #1;
        chk("rr_d_gnt", {31'd0, d_gnt}, 32'd1);
        @(negedge clk);
        d_req      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5A5A5;
        #1;
        chk("rr_pre_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rr_async_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rr_async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rr_d_rdata", d_rdata, 32'hA5A5A5A5);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rr_late_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rr_late_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        @(negedge clk);
        #1;
        chk("rr_late2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rr_idle_mem_req", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Single-port memory arbiter for the pipelined RV32I core: shares one unified instruction/data memory port between the fetch stage (read-only) and the memory stage (loads and stores, byte-enabled). Sequences one transaction at a time through a request/grant/response handshake on the memory side. Load/store data has priority over fetch. An optional starvation guard bounds how long fetch can be locked out. Sits between the IF/MEM pipeline stages and the memory wrapper.

## Interface
- STARVE_LIMIT, 4: consecutive data grants with fetch pending before fetch is forced (range 1..15); used only with the guard compiled in.
- clk  input  1  core clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- if_req  input  1  fetch request; held with if_addr stable until if_gnt
- if_addr  input  32  fetch byte address
- if_flush  input  1  branch/jump redirect; discard the in-flight fetch response
- if_gnt  output  1  fetch request accepted by memory this cycle
- if_rvalid  output  1  fetch read data valid
- if_rdata  output  32  fetch read data (equals mem_rdata)
- d_req  input  1  data request; held with all d_* fields stable until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_be  input  4  byte enables (0001 byte, 0011 half, 1111 word)
- d_addr  input  32  data byte address
- d_wdata  input  32  store data
- d_gnt  output  1  data request accepted by memory this cycle
- d_rvalid  output  1  load data valid
- d_rdata  output  32  load data (equals mem_rdata)
- mem_req  output  1  request to memory
- mem_we, mem_be, mem_addr, mem_wdata  output  1/4/32/32  request fields from the current owner
- mem_gnt  input  1  memory accepts the request this cycle
- mem_rvalid  input  1  read response valid (reads only; stores get no response)
- mem_rdata  input  32  read response data

## Operation
- FSM states IDLE, REQ, RSP; registers: state, owner (IF/D), drop flag, starve counter (4 bits).
- IDLE: if d_req, owner<=D (unless guard forces IF); else if if_req, owner<=IF; go REQ. No request: stay.
- REQ: mem_req=1; mem_* fields muxed from owner inputs. On mem_gnt: owner's gnt=1 same cycle (combinational); store -> IDLE; load or fetch -> RSP.
- RSP: wait for mem_rvalid; forward as d_rvalid or if_rvalid for one cycle; -> IDLE.
- Outside REQ: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Flush: if_flush while owner=IF in REQ or RSP sets drop; transaction still completes on memory side, but if_rvalid suppressed for that response. Drop cleared on return to IDLE. if_flush in IDLE or with owner=D: no effect.
- mem_gnt outside REQ and mem_rvalid outside RSP: ignored.
- gnt outputs never asserted for the non-owner.

## Timing
- Reset: state IDLE, owner IF, drop 0, counter 0; all outputs 0 except if_rdata/d_rdata (follow mem_rdata).
- Arbitration decision registered: req seen cycle N -> mem_req cycle N+1.
- Minimum read: req N, mem_req+gnt N+1, mem_rvalid N+2 -> rvalid N+2 (combinational forward), IDLE at N+3, next mem_req N+4.
- Minimum store: req N, mem_req+gnt N+1, IDLE N+2.
- Both reqs in same IDLE cycle: D wins (absent guard override).
- Reset mid-transaction: immediate return to IDLE, pending response lost; memory wrapper is reset on the same rstn.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: counter increments on each D arbitration win while if_req=1, clears on any IF win or when if_req=0 at arbitration. When counter==STARVE_LIMIT and if_req=1, IF wins regardless of d_req; counter clears.
- Undefined: strict D priority, no counter, STARVE_LIMIT ignored.

## Test plan
- Lone fetch if_addr=0x100, memory gnt immediate, rvalid one cycle later with 0x00500093 -> if_gnt cycle 1, if_rvalid with 0x00500093 cycle 2, IDLE cycle 3.
- Simultaneous if_req and store d_addr=0x2000, d_be=0011, d_wdata=0xBEEF -> mem_req carries store first, d_gnt, no d_rvalid, then fetch issued 2 cycles later.
- mem_gnt held low 3 cycles in REQ -> mem_req and fields stable, no gnt, grant on 4th cycle.
- Fetch in RSP with if_flush pulsed -> mem_rvalid consumed, if_rvalid stays 0, next request accepted normally.
- Guard enabled, STARVE_LIMIT=2, d_req and if_req held continuously -> grant order D,D,IF,D,D,IF; guard disabled -> only D.
- rstn low while in RSP -> all outputs 0 asynchronously, state IDLE; late mem_rvalid after release produces no rvalid.
